// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface mc_controller_if #(
    parameter int ALUCTRL_W = 4
);
    logic [5:0]           op;
    logic [5:0]           funct;
    logic                 zero;
    logic                 less;
    logic                 iord;
    logic                 memwrite;
    logic                 irwrite;
    logic                 regdst;
    logic                 memtoreg;
    logic                 regwrite;
    logic                 alusrca;
    logic [1:0]           alusrcb;
    logic [1:0]           pcsrc;
    logic                 pcen;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic                 illegal;

    modport master (
        input  op, funct, zero, less,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
        output alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal
    );

    modport slave (
        output op, funct, zero, less,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
        input  alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS Moore controller with parametrised memory wait states.
// Optional ble instruction (op 011111) is built when MC_BLE_EN is defined.
module mc_controller #(
    parameter int MEM_LAT   = 0,
    parameter int ALUCTRL_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
        RTYPEWB, ADDIEX, ADDIWB, BEQEX, BLEEX, JEX
    } state_t;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;
    localparam logic [3:0] A_BAD = 4'b1111;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BLE  = 6'b011111;

    state_t     state, nxt;
    logic [3:0] wcnt;
    logic       last;
    logic       ill_q;
    logic       op_bad;
    logic       fn_bad;
    logic [3:0] fn_alu;
    logic [3:0] alu;
    logic       pcwrite;

    assign last = (wcnt == 4'(MEM_LAT));

    always_comb begin
        fn_bad = 1'b0;
        unique case (bus.funct)
            6'b100000: fn_alu = A_ADD;
            6'b100010: fn_alu = A_SUB;
            6'b100100: fn_alu = A_AND;
            6'b100101: fn_alu = A_OR;
            6'b101010: fn_alu = A_SLT;
            default: begin
                fn_alu = A_BAD;
                fn_bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        nxt    = state;
        op_bad = 1'b0;
        unique case (state)
            FETCH:   if (last) nxt = DECODE;
            DECODE: begin
                unique case (bus.op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RT:        nxt = RTYPEEX;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_BEQ:       nxt = BEQEX;
                    OP_J:         nxt = JEX;
`ifdef MC_BLE_EN
                    OP_BLE:       nxt = BLEEX;
`endif
                    default: begin
                        nxt    = FETCH;
                        op_bad = 1'b1;
                    end
                endcase
            end
            MEMADR:  nxt = (bus.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (last) nxt = MEMWB;
            MEMWB:   nxt = FETCH;
            MEMWR:   if (last) nxt = FETCH;
            RTYPEEX: nxt = RTYPEWB;
            RTYPEWB: nxt = FETCH;
            ADDIEX:  nxt = ADDIWB;
            ADDIWB:  nxt = FETCH;
            BEQEX:   nxt = FETCH;
`ifdef MC_BLE_EN
            BLEEX:   nxt = FETCH;
`endif
            JEX:     nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    // illegal is held from detection until the next entry into FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            wcnt  <= 4'd0;
            ill_q <= 1'b0;
        end else begin
            state <= nxt;
            wcnt  <= (nxt != state) ? 4'd0 : wcnt + 4'd1;
            if (op_bad || (state == RTYPEEX && fn_bad))
                ill_q <= 1'b1;
            else if (nxt == FETCH && state != FETCH)
                ill_q <= 1'b0;
        end
    end

    always_comb begin
        bus.iord     = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        bus.pcen     = 1'b0;
        alu          = A_AND;
        pcwrite      = 1'b0;
        unique case (state)
            FETCH: begin
                bus.alusrcb = 2'b01;
                alu         = A_ADD;
                bus.irwrite = last;
                pcwrite     = last;
            end
            DECODE: begin
                bus.alusrcb = 2'b11;
                alu         = A_ADD;
            end
            MEMADR, ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                alu         = A_ADD;
            end
            MEMRD:   bus.iord = 1'b1;
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = last;
            end
            RTYPEEX: begin
                bus.alusrca = 1'b1;
                alu         = fn_alu;
            end
            RTYPEWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            ADDIWB:  bus.regwrite = 1'b1;
            BEQEX: begin
                bus.alusrca = 1'b1;
                alu         = A_SUB;
                bus.pcsrc   = 2'b01;
                bus.pcen    = bus.zero;
            end
`ifdef MC_BLE_EN
            BLEEX: begin
                bus.alusrca = 1'b1;
                alu         = A_SUB;
                bus.pcsrc   = 2'b01;
                bus.pcen    = bus.zero | bus.less;
            end
`endif
            JEX: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            default: ;
        endcase
        bus.pcen       = bus.pcen | pcwrite;
        bus.alucontrol = ALUCTRL_W'(alu);
    end

    assign bus.illegal = ill_q;
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller at MEM_LAT 0, 2 and 3.
// Output bundles are packed {iord,mw,irw,rd,mtr,rw,asa,asb,pcs,pcen,alu,ill}.
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   mwc2 = 0;
    int   mwc3 = 0;

    always #5 clk = ~clk;

    mc_controller_if #(.ALUCTRL_W(4)) b0 ();
    mc_controller_if #(.ALUCTRL_W(4)) b2 ();
    mc_controller_if #(.ALUCTRL_W(4)) b3 ();

    mc_controller #(.MEM_LAT(0), .ALUCTRL_W(4)) d0 (
        .clk(clk), .reset(reset), .bus(b0.master));
    mc_controller #(.MEM_LAT(2), .ALUCTRL_W(4)) d2 (
        .clk(clk), .reset(reset), .bus(b2.master));
    mc_controller #(.MEM_LAT(3), .ALUCTRL_W(4)) d3 (
        .clk(clk), .reset(reset), .bus(b3.master));

    always @(posedge clk) begin
        if (b2.memwrite) mwc2 <= mwc2 + 1;
        if (b3.memwrite) mwc3 <= mwc3 + 1;
    end

    function automatic logic [16:0] ex(
        input logic iord, mw, irw, rd, mtr, rw, asa,
        input logic [1:0] asb, pcs,
        input logic pce,
        input logic [3:0] alu,
        input logic ill);
        return {iord, mw, irw, rd, mtr, rw, asa, asb, pcs, pce, alu, ill};
    endfunction

    function automatic logic [16:0] fe(input logic lst, input logic ill);
        return ex(0,0,lst,0,0,0,0,2'b01,2'b00,lst,4'h2,ill);
    endfunction
    function automatic logic [16:0] de(input logic ill);
        return ex(0,0,0,0,0,0,0,2'b11,2'b00,0,4'h2,ill);
    endfunction
    function automatic logic [16:0] ma();
        return ex(0,0,0,0,0,0,1,2'b10,2'b00,0,4'h2,0);
    endfunction
    function automatic logic [16:0] mr();
        return ex(1,0,0,0,0,0,0,2'b00,2'b00,0,4'h0,0);
    endfunction
    function automatic logic [16:0] mwb();
        return ex(0,0,0,0,1,1,0,2'b00,2'b00,0,4'h0,0);
    endfunction
    function automatic logic [16:0] mwr(input logic lst);
        return ex(1,lst,0,0,0,0,0,2'b00,2'b00,0,4'h0,0);
    endfunction
    function automatic logic [16:0] rex(input logic [3:0] a, input logic ill);
        return ex(0,0,0,0,0,0,1,2'b00,2'b00,0,a,ill);
    endfunction
    function automatic logic [16:0] rwb(input logic ill);
        return ex(0,0,0,1,0,1,0,2'b00,2'b00,0,4'h0,ill);
    endfunction
    function automatic logic [16:0] awb();
        return ex(0,0,0,0,0,1,0,2'b00,2'b00,0,4'h0,0);
    endfunction
    function automatic logic [16:0] br(input logic pce);
        return ex(0,0,0,0,0,0,1,2'b00,2'b01,pce,4'h6,0);
    endfunction
    function automatic logic [16:0] jx();
        return ex(0,0,0,0,0,0,0,2'b00,2'b10,1,4'h0,0);
    endfunction

    function automatic logic [16:0] sig0();
        return {b0.iord, b0.memwrite, b0.irwrite, b0.regdst, b0.memtoreg,
                b0.regwrite, b0.alusrca, b0.alusrcb, b0.pcsrc, b0.pcen,
                b0.alucontrol, b0.illegal};
    endfunction
    function automatic logic [16:0] sig2();
        return {b2.iord, b2.memwrite, b2.irwrite, b2.regdst, b2.memtoreg,
                b2.regwrite, b2.alusrca, b2.alusrcb, b2.pcsrc, b2.pcen,
                b2.alucontrol, b2.illegal};
    endfunction
    function automatic logic [16:0] sig3();
        return {b3.iord, b3.memwrite, b3.irwrite, b3.regdst, b3.memtoreg,
                b3.regwrite, b3.alusrca, b3.alusrcb, b3.pcsrc, b3.pcen,
                b3.alucontrol, b3.illegal};
    endfunction

    // reset released just after a falling edge; cycle 1 is sampled at once
    task automatic start();
        reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] e[$];
        int base;
        b2.op = 6'b101011;
        start();
        base = mwc2;
        checks++;
        if (sig0() !== fe(1, 0)) begin
            errors++;
            $display("FAIL reset_l0 got %h want %h", sig0(), fe(1, 0));
        end
        e = '{fe(0,0), fe(0,0), fe(1,0), de(0), ma(), mwr(0), mwr(0)};
        foreach (e[i]) begin
            if (i > 0) step();
            checks++;
            if (sig2() !== e[i]) begin
                errors++;
                $display("FAIL reset_sw_c%0d got %h want %h", i + 1, sig2(), e[i]);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (sig2() !== fe(0, 0)) begin
            errors++;
            $display("FAIL reset_abort got %h want %h", sig2(), fe(0, 0));
        end
        step();
        step();
        checks++;
        if (sig2() !== fe(0, 0) || mwc2 != base) begin
            errors++;
            $display("FAIL reset_hold got %h/%0d want %h/0", sig2(), mwc2 - base, fe(0, 0));
        end
    endtask

    task automatic test_lw();
        logic [16:0] e[$];
        b0.op = 6'b100011;
        start();
        e = '{fe(1,0), de(0), ma(), mr(), mwb(), fe(1,0)};
        foreach (e[i]) begin
            if (i > 0) step();
            checks++;
            if (sig0() !== e[i]) begin
                errors++;
                $display("FAIL lw_c%0d got %h want %h", i + 1, sig0(), e[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [16:0] e[$];
        int base;
        b3.op = 6'b101011;
        start();
        base = mwc3;
        e = '{fe(0,0), fe(0,0), fe(0,0), fe(1,0), de(0), ma(),
              mwr(0), mwr(0), mwr(0), mwr(1), fe(0,0)};
        foreach (e[i]) begin
            if (i > 0) step();
            checks++;
            if (sig3() !== e[i]) begin
                errors++;
                $display("FAIL sw_c%0d got %h want %h", i + 1, sig3(), e[i]);
            end
        end
        checks++;
        if (mwc3 - base != 1) begin
            errors++;
            $display("FAIL sw_pulses got %0d want 1", mwc3 - base);
        end
    endtask

    task automatic test_rtype();
        logic [16:0] e[$];
        b0.op    = 6'b000000;
        b0.funct = 6'b101010;
        start();
        e = '{fe(1,0), de(0), rex(4'h7,0), rwb(0), fe(1,0)};
        foreach (e[i]) begin
            if (i > 0) step();
            checks++;
            if (sig0() !== e[i]) begin
                errors++;
                $display("FAIL slt_c%0d got %h want %h", i + 1, sig0(), e[i]);
            end
        end
        b0.funct = 6'b100010;
        step();
        step();
        checks++;
        if (sig0() !== rex(4'h6, 0)) begin
            errors++;
            $display("FAIL sub_ex got %h want %h", sig0(), rex(4'h6, 0));
        end
        b0.funct = 6'b111111;
        start();
        e = '{fe(1,0), de(0), rex(4'hf,0), rwb(1), fe(1,0)};
        foreach (e[i]) begin
            if (i > 0) step();
            checks++;
            if (sig0() !== e[i]) begin
                errors++;
                $display("FAIL badfn_c%0d got %h want %h", i + 1, sig0(), e[i]);
            end
        end
    endtask

    task automatic test_addi();
        logic [16:0] e[$];
        b0.op = 6'b001000;
        start();
        e = '{fe(1,0), de(0), ma(), awb(), fe(1,0)};
        foreach (e[i]) begin
            if (i > 0) step();
            checks++;
            if (sig0() !== e[i]) begin
                errors++;
                $display("FAIL addi_c%0d got %h want %h", i + 1, sig0(), e[i]);
            end
        end
    endtask

    task automatic test_branch();
        b0.op   = 6'b000100;
        b0.zero = 1'b0;
        b0.less = 1'b1;
        start();
        step();
        step();
        checks++;
        if (sig0() !== br(0)) begin
            errors++;
            $display("FAIL beq_nt got %h want %h", sig0(), br(0));
        end
        b0.zero = 1'b1;
        #1;
        checks++;
        if (sig0() !== br(1)) begin
            errors++;
            $display("FAIL beq_t got %h want %h", sig0(), br(1));
        end
        step();
        checks++;
        if (sig0() !== fe(1, 0)) begin
            errors++;
            $display("FAIL beq_next got %h want %h", sig0(), fe(1, 0));
        end
    endtask

    task automatic test_ble();
        b0.op   = 6'b011111;
        b0.zero = 1'b0;
        b0.less = 1'b1;
        start();
        step();
        checks++;
        if (sig0() !== de(0)) begin
            errors++;
            $display("FAIL ble_dec got %h want %h", sig0(), de(0));
        end
        step();
`ifdef MC_BLE_EN
        checks++;
        if (sig0() !== br(1)) begin
            errors++;
            $display("FAIL ble_less got %h want %h", sig0(), br(1));
        end
        b0.less = 1'b0;
        #1;
        checks++;
        if (sig0() !== br(0)) begin
            errors++;
            $display("FAIL ble_gt got %h want %h", sig0(), br(0));
        end
        step();
        checks++;
        if (sig0() !== fe(1, 0)) begin
            errors++;
            $display("FAIL ble_next got %h want %h", sig0(), fe(1, 0));
        end
`else
        checks++;
        if (sig0() !== fe(1, 1)) begin
            errors++;
            $display("FAIL ble_off got %h want %h", sig0(), fe(1, 1));
        end
`endif
    endtask

    task automatic test_jump();
        logic [16:0] e[$];
        b0.op = 6'b000010;
        start();
        e = '{fe(1,0), de(0), jx(), fe(1,0)};
        foreach (e[i]) begin
            if (i > 0) step();
            checks++;
            if (sig0() !== e[i]) begin
                errors++;
                $display("FAIL j_c%0d got %h want %h", i + 1, sig0(), e[i]);
            end
        end
    endtask

    task automatic test_illegal_op();
        logic [16:0] e[$];
        b2.op = 6'b111111;
        start();
        e = '{fe(0,0), fe(0,0), fe(1,0), de(0), fe(0,1), fe(0,1), fe(1,1), de(1)};
        foreach (e[i]) begin
            if (i > 0) step();
            checks++;
            if (sig2() !== e[i]) begin
                errors++;
                $display("FAIL badop_c%0d got %h want %h", i + 1, sig2(), e[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        b0.op = '0; b0.funct = '0; b0.zero = 1'b0; b0.less = 1'b0;
        b2.op = '0; b2.funct = '0; b2.zero = 1'b0; b2.less = 1'b0;
        b3.op = '0; b3.funct = '0; b3.zero = 1'b0; b3.less = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_addi();
        test_branch();
        test_ble();
        test_jump();
        test_illegal_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle successor to the single-cycle MIPS controller: a Moore FSM that sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, addi, beq, j and (optionally) ble, over a shared memory with parametrised access latency. It drives the multicycle datapath's mux selects, write enables and ALU control, and produces a combined PC enable from the branch conditions `zero` and `less`. It replaces the single-cycle controller when the datapath moves to the multicycle organisation.

## Interface
- `MEM_LAT`, 0: extra wait cycles per memory access, 0..15; each access state holds for MEM_LAT+1 cycles.
- `ALUCTRL_W`, 4: width of `alucontrol`, ≥4; codes are zero-extended.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 6: instruction opcode, from the instruction register.
- `funct` in 6: R-type function field.
- `zero` in 1: ALU result == 0.
- `less` in 1: ALU signed result < 0 (for A−B).
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register load.
- `regdst` out 1: 1 = rd, 0 = rt.
- `memtoreg` out 1: 1 = data register, 0 = ALUOut.
- `regwrite` out 1: register file write.
- `alusrca` out 1: 0 = PC, 1 = A.
- `alusrcb` out 2: 00 B, 01 const 4, 10 signimm, 11 signimm<<2.
- `pcsrc` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `pcen` out 1: PC register enable.
- `alucontrol` out ALUCTRL_W: ALU operation.
- `illegal` out 1: unrecognised op/funct seen this instruction; sticky until the next FETCH.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, ADDIEX, ADDIWB, BEQEX, BLEEX, JEX.
- FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00. Holds for MEM_LAT+1 cycles on the wait counter `wcnt`. irwrite and pcwrite (into pcen) assert only in the final cycle. Then → DECODE.
- DECODE: alusrca=0, alusrcb=11, alucontrol=add (branch target into ALUOut). Dispatch on op:
  - 100011/101011 → MEMADR
  - 000000 → RTYPEEX
  - 001000 → ADDIEX
  - 000100 → BEQEX
  - 000010 → JEX
  - 011111 → BLEEX
  - Anything else: set illegal and → FETCH.
- MEMADR: alusrca=1, alusrcb=10, add. → MEMRD (lw) or MEMWR (sw).
- MEMRD: iord=1, held MEM_LAT+1 cycles, then → MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. → FETCH.
- MEMWR: iord=1, held MEM_LAT+1 cycles. memwrite asserts in the final cycle only, as a single pulse. → FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, funct-decoded ALU. → RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. → FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. → ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. → FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01. pcen = zero. → FETCH.
- BLEEX: as BEQEX, but pcen = zero | less. → FETCH.
- JEX: pcsrc=10, pcen=1. → FETCH.
- ALU codes: and 0000, or 0001, add 0010, sub 0110, slt 0111.
- Funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct in RTYPEEX gives alucontrol=1111 and sets illegal; RTYPEWB still writes.
- Unlisted outputs are 0 in every state.
- `wcnt` resets to 0 on every state change.

## Timing
- Reset (async, immediate): state=FETCH, wcnt=0, illegal=0.
  - Outputs immediately follow FETCH decode.
  - With MEM_LAT=0, irwrite=pcen=1 in the first post-reset cycle.
  - Reset mid-instruction aborts it with no further regwrite or memwrite.
- All outputs are Moore functions of state/wcnt, except pcen in BEQEX/BLEEX, which is combinational on zero/less the same cycle.
- Instruction latency at MEM_LAT=L:
  - lw: 5+2L cycles
  - sw: 4+2L
  - R-type and addi: 4+L
  - beq, ble and j: 3+L
  - illegal op: 2+L
- illegal is registered: it rises the cycle after DECODE/RTYPEEX detects the fault and clears on entering FETCH.

## Configuration
- `MC_BLE_EN` defined: op 011111 decodes to BLEEX as above.
- `MC_BLE_EN` undefined: BLEEX is not built. Op 011111 is illegal, returning DECODE → FETCH with illegal set and no PC update beyond PC+4.

## Test plan
- Reset asserted mid-MEMWR (MEM_LAT=2, wcnt=1) → state FETCH immediately; memwrite never pulses; illegal=0.
- lw with MEM_LAT=0 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; regwrite=1, memtoreg=1, regdst=0 only in cycle 5.
- sw with MEM_LAT=3 → FETCH held 4 cycles with irwrite only in the 4th; MEMWR held 4 cycles with a single memwrite pulse in the last; 10 cycles total.
- R-type funct 101010 → alucontrol=0111 in RTYPEEX; funct 111111 → alucontrol=1111, illegal=1 from the next cycle until FETCH.
- beq with zero=0 → pcen=0 in BEQEX. ble (MC_BLE_EN) with zero=0, less=1 → pcen=1, pcsrc=01.
- ble built without MC_BLE_EN, op 011111 → DECODE → FETCH, illegal=1; j op 000010 → pcsrc=10, pcen=1, 3 cycles.
